// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: access size encodings, MEM-stage FSM states and store lane helpers.
package pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    MA_IDLE = 2'b00,
    MA_BUSY = 2'b01,
    MA_DONE = 2'b10
  } ma_state_e;

  // The reserved size code 2'b11 falls into the word branch in every helper below.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: selects the addressed byte or half of a read word
// and sign- or zero-extends it to 32 bits.
module load_align
  import pipe_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = i_unsigned ? {24'h0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_data = i_unsigned ? {16'h0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: drives the data-memory req/ack bus, aligns load data and
// stalls upstream stages while an access is outstanding.
//   state   | meaning
//   MA_IDLE | no access outstanding; launches aligned memops
//   MA_BUSY | request on the bus, waiting for ack or timeout
//   MA_DONE | result presented to MEM/WB for one cycle
module mem_access_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_aluout,
  input  logic [31:0]       ex_writedata,
  input  logic [4:0]        ex_writereg,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       aluout_out,
  output logic [31:0]       readdata_out,
  output logic [4:0]        writereg_out,
  output logic              misalign,
  output logic              bus_err
);

  ma_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;
  logic [1:0]       r_off;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [31:0]      r_rdata;

  logic             w_memop;
  logic             w_aligned;
  logic [1:0]       w_off;
  logic [31:0]      w_load;
  logic             w_timeout;

  assign w_off     = ex_aluout[1:0];
  assign w_memop   = ex_valid & (ex_memread | ex_memwrite);
  assign w_aligned = is_aligned(ex_size, w_off);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Offset/size/sign are latched with the request so alignment does not depend
  // on EX/MEM staying frozen.
  load_align u_load_align (
    .i_rdata    (dmem_rdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= MA_IDLE;
      r_cnt      <= '0;
      r_abort    <= 1'b0;
      r_off      <= 2'b00;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_rdata    <= 32'h0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'h0;
      dmem_be    <= 4'h0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        MA_IDLE: begin
          r_abort <= 1'b0;
          if (w_memop && w_aligned) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_memwrite;
            dmem_addr  <= {ex_aluout[ADDR_W-1:2], 2'b00};
            dmem_wdata <= store_wdata(ex_size, ex_writedata);
            dmem_be    <= store_be(ex_size, w_off);
            r_off      <= w_off;
            r_size     <= ex_size;
            r_unsigned <= ex_unsigned;
            r_cnt      <= '0;
            r_state    <= MA_BUSY;
          end else if (w_memop) begin
            misalign <= 1'b1;
          end
        end
        MA_BUSY: begin
          if (dmem_ack) begin
            r_rdata  <= w_load;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'h0;
            r_state  <= MA_DONE;
          end else if (w_timeout) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'h0;
            bus_err  <= 1'b1;
            r_abort  <= 1'b1;
            r_state  <= MA_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MA_DONE: r_state <= MA_IDLE;
        default: r_state <= MA_IDLE;
      endcase
    end
  end

  always_comb begin
    stall        = 1'b0;
    writereg_out = ex_writereg;
    readdata_out = 32'h0;
    case (r_state)
      MA_IDLE: begin
        stall = w_memop & w_aligned;
        if (w_memop && !w_aligned) writereg_out = 5'd0;
      end
      MA_BUSY: stall = 1'b1;
      MA_DONE: begin
        readdata_out = r_rdata;
        if (r_abort) writereg_out = 5'd0;
      end
      default: stall = 1'b0;
    endcase
  end

  assign aluout_out = 32'(ex_aluout);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// loads/stores/non-memory ops against a byte-level reference model.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic        ex_unsigned = 1'b0;
  logic [31:0] ex_aluout = 32'h0, ex_writedata = 32'h0;
  logic [4:0]  ex_writereg = 5'd0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic [31:0] aluout_out, readdata_out;
  logic [4:0]  writereg_out;
  logic        misalign, bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_aluout(ex_aluout),
    .ex_writedata(ex_writedata), .ex_writereg(ex_writereg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .aluout_out(aluout_out), .readdata_out(readdata_out), .writereg_out(writereg_out),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_writereg = 5'd0;
  endtask

  // Called at posedge+1 with the unit idle; returns at posedge+1 with the unit idle.
  task automatic do_op(input bit v, input bit rd, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] wreg, input int ack_at, input logic [31:0] rdat);
    bit          memop, aligned, aborted;
    int          nbusy, stalls, oi;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    logic [7:0]  bt[4];

    memop = v && (rd || wr);
    oi    = int'(addr[1:0]);
    case (sz)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (oi % 2 == 0);
      default: aligned = (oi == 0);
    endcase

    ebe = 4'h0; ewd = 32'h0;
    for (int i = 0; i < 4; i++) bt[i] = rdat[8*i +: 8];
    if (sz == 2'b00) begin
      ebe[oi] = 1'b1;
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[7:0];
      eld = {{24{bt[oi][7] & ~uns}}, bt[oi]};
    end else if (sz == 2'b01) begin
      ebe[oi] = 1'b1; ebe[(oi + 1) % 4] = 1'b1;
      for (int i = 0; i < 2; i++) ewd[16*i +: 16] = wd[15:0];
      eld = {{16{bt[(oi + 1) % 4][7] & ~uns}}, bt[(oi + 1) % 4], bt[oi]};
    end else begin
      ebe = 4'hF; ewd = wd; eld = rdat;
    end
    aborted = !(ack_at >= 0 && ack_at < TMO);
    nbusy   = aborted ? TMO : ack_at + 1;

    ex_valid = v; ex_memread = rd; ex_memwrite = wr; ex_size = sz; ex_unsigned = uns;
    ex_aluout = addr; ex_writedata = wd; ex_writereg = wreg;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    @(negedge clk);
    chk("aluout", aluout_out, addr);
    chk("stall_first", 32'(stall), 32'(memop && aligned));
    chk("wreg_first", 32'(writereg_out), (memop && !aligned) ? 32'd0 : 32'(wreg));
    chk("req_first", 32'(dmem_req), 32'd0);
    chk("rdout_first", readdata_out, 32'h0);
    stalls = int'(stall);
    @(posedge clk); #1;

    if (!(memop && aligned)) begin
      idle_inputs(); dmem_ack = 1'b0;
      @(negedge clk);
      chk("misalign", 32'(misalign), 32'(memop && !aligned));
      chk("req_idle", 32'(dmem_req), 32'd0);
      chk("stall_idle", 32'(stall), 32'd0);
      @(posedge clk); #1;
      return;
    end

    for (int b = 0; b < nbusy; b++) begin
      dmem_ack = (b == ack_at); dmem_rdata = (b == ack_at) ? rdat : $urandom;
      @(negedge clk);
      stalls += int'(stall);
      chk("req_busy", 32'(dmem_req), 32'd1);
      chk("addr", dmem_addr, {addr[31:2], 2'b00});
      chk("be", 32'(dmem_be), 32'(ebe));
      chk("we", 32'(dmem_we), 32'(wr));
      if (wr) chk("wdata", dmem_wdata, ewd);
      chk("buserr_busy", 32'(bus_err), 32'd0);
      @(posedge clk); #1;
    end

    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    @(negedge clk);
    chk("stall_cycles", 32'(stalls), 32'(nbusy + 1));
    chk("stall_done", 32'(stall), 32'd0);
    chk("req_done", 32'(dmem_req), 32'd0);
    chk("buserr", 32'(bus_err), 32'(aborted));
    chk("wreg_done", 32'(writereg_out), aborted ? 32'd0 : 32'(wreg));
    if (!aborted) begin
      chk("be_done", 32'(dmem_be), 32'd0);
      if (rd) chk("readdata", readdata_out, eld);
    end
    @(posedge clk); #1;
    idle_inputs(); dmem_ack = 1'b0;
    @(negedge clk);
    chk("req_after", 32'(dmem_req), 32'd0);
    chk("buserr_after", 32'(bus_err), 32'd0);
    chk("rdout_after", readdata_out, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    int kind, ack_at;
    logic [1:0] sz;

    #2;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_buserr", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    do_op(1, 0, 0, 2'b10, 0, 32'h1234, 32'h0, 5'd5, -1, 32'h0);
    do_op(1, 1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF);
    do_op(1, 1, 0, 2'b00, 0, 32'h103, 32'h0, 5'd8, 0, 32'h80FFFFFF);
    do_op(1, 1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd9, 1, 32'h80FFFFFF);
    do_op(1, 1, 0, 2'b01, 0, 32'h102, 32'h0, 5'd10, 0, 32'h80FFFFFF);
    do_op(1, 0, 1, 2'b00, 0, 32'h101, 32'hAB, 5'd0, 0, 32'h0);
    do_op(1, 0, 1, 2'b01, 0, 32'h102, 32'h1234, 5'd0, 3, 32'h0);
    do_op(1, 1, 0, 2'b10, 0, 32'h102, 32'h0, 5'd11, 0, 32'h0);
    do_op(1, 1, 0, 2'b10, 0, 32'h104, 32'h0, 5'd12, -1, 32'h0);
    do_op(1, 1, 0, 2'b11, 0, 32'h108, 32'h0, 5'd13, 0, 32'h01234567);

    // Reset in the middle of an outstanding access, then a stray ack.
    ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_size = 2'b10;
    ex_aluout = 32'h200; ex_writereg = 5'd3; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; idle_inputs();
    #1;
    chk("rstbusy_req", 32'(dmem_req), 32'd0);
    chk("rstbusy_stall", 32'(stall), 32'd0);
    chk("rstbusy_be", 32'(dmem_be), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("lateack_stall", 32'(stall), 32'd0);
    chk("lateack_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("lateack_rdout", readdata_out, 32'h0);
    chk("lateack_buserr", 32'(bus_err), 32'd0);
    chk("lateack_misalign", 32'(misalign), 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      kind   = $urandom_range(0, 3);
      sz     = 2'($urandom_range(0, 3));
      ack_at = $urandom_range(0, 6) - 1;
      case (kind)
        0: do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, sz, 0, $urandom,
                 $urandom, 5'($urandom), ack_at, $urandom);
        3: do_op(1, 0, 1, sz, 0, $urandom, $urandom, 5'd0, ack_at, $urandom);
        default: do_op(1, 1, 0, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
                       5'($urandom), ack_at, $urandom);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
